// File: rtl/mem_seq_pkg.sv
// Shared types for the MEM-stage vector sequencer: lane word, lane vector and FSM states.
package mem_seq_pkg;

  localparam int LANES_DEF = 4;

  typedef logic [31:0] word_t;
  typedef word_t [LANES_DEF-1:0] lane_vec_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    STORE      = 2'd1,
    LOAD       = 2'd2,
    LOAD_DRAIN = 2'd3
  } seq_state_e;

endpackage

// File: rtl/mem_vector_seq_lane_buf.sv
// Lane buffer: holds store data after accept and collects load data beat by beat.
// Parallel load has priority over the indexed single-lane write.
module mem_seq_lane_buf
  import mem_seq_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int IDX_W = $clog2(LANES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_load,
  input  word_t [LANES-1:0]      i_vec,
  input  logic                   i_we,
  input  logic [IDX_W-1:0]       i_widx,
  input  word_t                  i_wdata,
  input  logic [IDX_W-1:0]       i_ridx,
  output word_t                  o_rdata,
  output word_t [LANES-1:0]      o_vec
);

  word_t [LANES-1:0] r_buf;

  // Buffer storage: whole-vector capture on accept, single lane on load beats.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_buf <= '0;
    end else if (i_load) begin
      r_buf <= i_vec;
    end else if (i_we) begin
      r_buf[i_widx] <= i_wdata;
    end
  end

  assign o_rdata = r_buf[i_ridx];
  assign o_vec   = r_buf;

endmodule

// File: rtl/mem_vector_seq.sv
// MEM-stage vector sequencer. Serialises vector stores/loads to a single-port
// 32-bit memory one lane per cycle, stalls upstream while busy, and passes
// non-memory instructions through with one cycle of latency.
// Optional build macro: MEM_SEQ_PERF_CNT_EN adds stall_cycles_out, a saturating
// count of stalled cycles.
//
// state      | meaning
// IDLE       | accepting; ALU ops pass through, mem ops latched
// STORE      | one write beat per cycle, retire after last beat
// LOAD       | one read beat per cycle, capture previous beat's data
// LOAD_DRAIN | capture last lane and retire
module mem_vector_seq
  import mem_seq_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              regWrite_in,
  input  logic              memWrite_in,
  input  logic              select_in,
  input  logic              updateCnt_in,
  input  logic [3:0]        rd_in,
  input  logic [3:0]        resCompare_in,
  input  logic [31:0]       aluRes0_in,
  input  logic [31:0]       aluRes1_in,
  input  logic [31:0]       aluRes2_in,
  input  logic [31:0]       aluRes3_in,
  input  logic [ADDR_W-1:0] base_addr_in,
  input  logic [31:0]       mem_rdata,
  output logic              stall_out,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic              regWrite_out,
  output logic              updateCnt_out,
  output logic [3:0]        rd_out,
  output logic [3:0]        resCompare_out,
  output logic [31:0]       res0_out,
  output logic [31:0]       res1_out,
  output logic [31:0]       res2_out,
  output logic [31:0]       res3_out
`ifdef MEM_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles_out
`endif
);

  localparam int BEAT_W = $clog2(LANES);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LANES - 1);

  seq_state_e        r_state;
  seq_state_e        w_state_nxt;
  logic [BEAT_W-1:0] r_beat;
  logic              w_last;
  logic              w_accept;

  logic              r_regWrite;
  logic              r_updateCnt;
  logic [3:0]        r_rd;
  logic [3:0]        r_resCompare;
  logic [ADDR_W-1:0] r_base;

  logic              r_regWrite_out;
  logic              r_updateCnt_out;
  logic [3:0]        r_rd_out;
  logic [3:0]        r_resCompare_out;
  word_t [LANES-1:0] r_res;

  word_t [LANES-1:0] w_in_vec;
  word_t [LANES-1:0] w_buf_vec;
  word_t [LANES-1:0] w_load_vec;
  word_t             w_buf_rdata;
  logic              w_buf_we;
  logic [BEAT_W-1:0] w_buf_widx;

  word_t             w_alu      [4];
  word_t             w_res_port [4];

  assign w_alu[0] = aluRes0_in;
  assign w_alu[1] = aluRes1_in;
  assign w_alu[2] = aluRes2_in;
  assign w_alu[3] = aluRes3_in;

  for (genvar i = 0; i < LANES; i++) begin : g_in_lane
    if (i < 4) begin : g_port
      assign w_in_vec[i] = w_alu[i];
    end else begin : g_zero
      assign w_in_vec[i] = '0;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_out_lane
    if (i < LANES) begin : g_lane
      assign w_res_port[i] = r_res[i];
    end else begin : g_zero
      assign w_res_port[i] = '0;
    end
  end

  assign w_last    = (r_beat == LAST_BEAT);
  assign w_accept  = (r_state == IDLE) && (memWrite_in || select_in);
  assign stall_out = (r_state != IDLE);

  mem_seq_lane_buf #(
    .LANES (LANES)
  ) u_lane_buf (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_accept),
    .i_vec   (w_in_vec),
    .i_we    (w_buf_we),
    .i_widx  (w_buf_widx),
    .i_wdata (mem_rdata),
    .i_ridx  (r_beat),
    .o_rdata (w_buf_rdata),
    .o_vec   (w_buf_vec)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, memory strobes and lane-buffer write control.
  always_comb begin
    w_state_nxt = r_state;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    w_buf_we    = 1'b0;
    w_buf_widx  = r_beat - BEAT_W'(1);
    w_load_vec  = w_buf_vec;
    w_load_vec[LANES-1] = mem_rdata;
    case (r_state)
      IDLE: begin
        if (memWrite_in) begin
          w_state_nxt = STORE;
        end else if (select_in) begin
          w_state_nxt = LOAD;
        end
      end
      STORE: begin
        mem_we    = 1'b1;
        mem_addr  = r_base + ADDR_W'(r_beat);
        mem_wdata = w_buf_rdata;
        if (w_last) begin
          w_state_nxt = IDLE;
        end
      end
      LOAD: begin
        mem_re   = 1'b1;
        mem_addr = r_base + ADDR_W'(r_beat);
        w_buf_we = (r_beat != '0);
        if (w_last) begin
          w_state_nxt = LOAD_DRAIN;
        end
      end
      LOAD_DRAIN: begin
        w_buf_we    = 1'b1;
        w_buf_widx  = LAST_BEAT;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Beat counter: advances through the lanes of a store or load, else parked at 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_beat <= '0;
    end else if (((r_state == STORE) || (r_state == LOAD)) && !w_last) begin
      r_beat <= r_beat + BEAT_W'(1);
    end else begin
      r_beat <= '0;
    end
  end

  // Control fields of an accepted memory instruction, held until retire.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_regWrite   <= 1'b0;
      r_updateCnt  <= 1'b0;
      r_rd         <= '0;
      r_resCompare <= '0;
      r_base       <= '0;
    end else if (w_accept) begin
      r_regWrite   <= regWrite_in;
      r_updateCnt  <= updateCnt_in;
      r_rd         <= rd_in;
      r_resCompare <= resCompare_in;
      r_base       <= base_addr_in;
    end
  end

  // Retire registers: pass-through in IDLE, memory results at the end of a sequence.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_regWrite_out   <= 1'b0;
      r_updateCnt_out  <= 1'b0;
      r_rd_out         <= '0;
      r_resCompare_out <= '0;
      r_res            <= '0;
    end else begin
      r_regWrite_out  <= 1'b0;
      r_updateCnt_out <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!(memWrite_in || select_in)) begin
            r_regWrite_out   <= regWrite_in;
            r_updateCnt_out  <= updateCnt_in;
            r_rd_out         <= rd_in;
            r_resCompare_out <= resCompare_in;
            r_res            <= w_in_vec;
          end
        end
        STORE: begin
          if (w_last) begin
            r_regWrite_out   <= r_regWrite;
            r_updateCnt_out  <= r_updateCnt;
            r_rd_out         <= r_rd;
            r_resCompare_out <= r_resCompare;
            r_res            <= w_buf_vec;
          end
        end
        LOAD_DRAIN: begin
          r_regWrite_out   <= r_regWrite;
          r_updateCnt_out  <= r_updateCnt;
          r_rd_out         <= r_rd;
          r_resCompare_out <= r_resCompare;
          r_res            <= w_load_vec;
        end
        default: ;
      endcase
    end
  end

  assign regWrite_out   = r_regWrite_out;
  assign updateCnt_out  = r_updateCnt_out;
  assign rd_out         = r_rd_out;
  assign resCompare_out = r_resCompare_out;
  assign res0_out       = w_res_port[0];
  assign res1_out       = w_res_port[1];
  assign res2_out       = w_res_port[2];
  assign res3_out       = w_res_port[3];

`ifdef MEM_SEQ_PERF_CNT_EN
  logic [31:0] r_stall_cycles;

  // Saturating count of cycles spent stalled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_cycles <= '0;
    end else if (stall_out && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles_out = r_stall_cycles;
`endif

endmodule

// File: doc/mem_vector_seq.md
Name: mem_vector_seq

Overview:
- MEM-stage consumer of the EXE/MEM pipeline register.
- Takes the four 32-bit lane results plus control.
- Serialises vector stores into, and vector loads out of, a single-port 32-bit data memory, one lane per cycle.
- Stalls upstream while busy and drives MEM/WB-side outputs; non-memory instructions pass through with one cycle of latency.

Parameters:
- LANES, 4, number of 32-bit lanes per vector (power of two, ≥2).
- ADDR_W, 16, data-memory word-address width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low; 0 at a clk edge resets.
- regWrite_in  in  1  writeback enable of incoming instruction.
- memWrite_in  in  1  vector store.
- select_in  in  1  vector load; ignored when memWrite_in=1.
- updateCnt_in  in  1  counter-update flag, passed through.
- rd_in  in  4  destination register.
- resCompare_in  in  4  per-lane compare result, passed through.
- aluRes0_in..aluRes3_in  in  32 each  lane data; store data for stores.
- base_addr_in  in  ADDR_W  vector base word address.
- mem_rdata  in  32  memory read data, valid 1 cycle after mem_re.
- stall_out  out  1  1 = hold EXE/MEM register (drives its stop).
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  32  memory write data.
- mem_we  out  1  write strobe.
- mem_re  out  1  read strobe.
- regWrite_out, updateCnt_out  out  1 each  one-cycle pulses per retired instruction.
- rd_out, resCompare_out  out  4 each  retired instruction fields.
- res0_out..res3_out  out  32 each  retired lane results.

Behaviour:
- States: IDLE, STORE, LOAD, LOAD_DRAIN. stall_out = (state != IDLE), decoded from state only; no combinational path from inputs.
- Reset (reset=0 at edge): state=IDLE, beat counter=0, every output 0. Aborts any in-flight operation; no further mem_we/mem_re.
- IDLE, memWrite_in=1: latch all inputs, go to STORE. Outputs for this instruction appear only at retire.
- IDLE, select_in=1, memWrite_in=0: latch, go to LOAD.
- IDLE, neither: register all fields to outputs at the next edge. regWrite_out/updateCnt_out are high for exactly that one cycle.
- STORE, beat k=0..LANES-1 (one per cycle): mem_we=1, mem_addr=base+k mod 2^ADDR_W, mem_wdata=lane k. After beat LANES-1: retire and go to IDLE. Retire outputs: res lanes = latched aluRes, regWrite_out = latched regWrite.
- LOAD, beat k: mem_re=1, mem_addr=base+k. mem_rdata is captured into lane k-1 in the cycle of beat k. After beat LANES-1, go to LOAD_DRAIN: capture lane LANES-1, retire with res lanes = loaded data, then go to IDLE.
- Latency from accept edge: store occupies LANES cycles with stall high; load occupies LANES+1 cycles.
- Both memWrite_in and select_in high: treated as store.
- While busy, regWrite_out=0 and updateCnt_out=0. Data outputs hold their last retired values.
- The instruction held upstream by stall is accepted in the IDLE cycle immediately after retire. No bubble is inserted beyond the stall.
- Address wrap: base=0xFFFF, k=1 gives 0x0000.
- mem_we and mem_re are never high in the same cycle.

Optional Feature:
- Macro MEM_SEQ_PERF_CNT_EN.
- Defined: adds output stall_cycles_out [31:0], which counts cycles with stall_out=1, saturates at 0xFFFFFFFF, and clears on reset.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package mem_seq_pkg: state enum, LANES_DEF, lane_vec_t (LANES×32 array), word_t.
- Sub-module mem_seq_lane_buf: LANES×32 buffer with parallel load, indexed single-lane write and indexed read. Used for both store data and load capture.

Test Plan:
- Reset: hold reset=0 for 2 cycles mid-store, at beat 2 → outputs 0, state IDLE, no mem_we afterwards.
- Store: base=0x0010, lanes 0xA0..0xA3, regWrite=0 → mem_we on 4 consecutive cycles at addr 0x10..0x13 with the matching data; stall high for 4 cycles; regWrite_out stays 0.
- Load: base=0x0020, memory 0x20..0x23 = 0x11,0x22,0x33,0x44, rd=5, regWrite=1 → stall for 5 cycles; res0..3_out = 0x11,0x22,0x33,0x44; rd_out=5; regWrite_out pulses 1 cycle.
- Pass-through: ALU op with res 0xDEADBEEF, rd=3 → outputs update at the next edge, stall never asserted.
- Back-to-back: store followed by an ALU op → ALU op retires the cycle after the store retires; wrap case base=0xFFFE touches 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Perf counter (MEM_SEQ_PERF_CNT_EN defined): one store plus one load → stall_cycles_out = 9.
